// File: rtl/ddr_rd_client.sv
// Fetch client for one DDR read-scheduler port: issues burst requests and buffers the returned
// 18-bit words in a FWFT FIFO. Define DDR_RD_CLIENT_CHECK_EN to enable the sticky err checker.
module ddr_rd_client #(
   parameter int unsigned WIDTH_Vaddr     = 20,
   parameter int unsigned WIDTH_nburst    = 12,
   parameter int unsigned WORDS_PER_BURST = 56,
   parameter int unsigned VADDR_STEP      = 64,
   parameter int unsigned DEPTH           = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [WIDTH_Vaddr-1:0]  start_Vaddr,
   input  logic [WIDTH_nburst-1:0] nburst,
   output logic                    block_req,
   output logic [WIDTH_Vaddr-1:0]  block_Vaddr,
   input  logic                    block_granted,
   output logic                    block_pause_ahead1,
   input  logic [17:0]             data18bit,
   input  logic                    data18bit_vld,
   output logic [17:0]             out_data,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned WcntW = $clog2(WORDS_PER_BURST + 1);

   typedef enum logic [1:0] {StIdle, StReq, StStream, StDone} state_e;

   state_e                  state_q, state_d;
   logic [WIDTH_Vaddr-1:0]  vaddr_q, vaddr_d;
   logic [WIDTH_nburst-1:0] left_q, left_d;
   logic [WcntW-1:0]        wcnt_q, wcnt_d;
   logic                    block_req_q, block_req_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    last_word;

   logic [17:0]             mem [DEPTH];
   logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]         count_q, count_d, pause_sum;
   logic                    out_vld_q, out_vld_d;
   logic                    push, pop;

   assign last_word = (state_q == StStream) && data18bit_vld &&
                      (wcnt_q == WcntW'(WORDS_PER_BURST - 1));

   always_comb begin
      state_d = state_q;
      vaddr_d = vaddr_q;
      left_d  = left_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (nburst != '0) begin
                  vaddr_d = start_Vaddr;
                  left_d  = nburst;
                  state_d = StReq;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StReq: begin
            if (block_granted) begin
               state_d = StStream;
               wcnt_d  = '0;
            end
         end
         StStream: begin
            if (data18bit_vld) begin
               if (last_word) begin
                  wcnt_d = '0;
                  left_d = left_q - WIDTH_nburst'(1);
                  if (left_q > WIDTH_nburst'(1)) begin
                     vaddr_d = vaddr_q + WIDTH_Vaddr'(VADDR_STEP);
                     state_d = StReq;
                  end else begin
                     state_d = StDone;
                  end
               end else begin
                  wcnt_d = wcnt_q + WcntW'(1);
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // The zero-burst path passes through StDone without pulsing; done follows one cycle later.
   always_comb begin
      done_d      = (last_word && !(left_q > WIDTH_nburst'(1))) ||
                    ((state_q == StDone) && !done_q);
      busy_d      = (state_d != StIdle) && !done_d;
      block_req_d = (state_d == StReq);
   end

   assign pop       = out_vld_q && out_rdy;
   assign push      = data18bit_vld && ((count_q != CntW'(DEPTH)) || pop);
   assign pause_sum = count_q + CntW'(data18bit_vld);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
      out_vld_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         vaddr_q     <= '0;
         left_q      <= '0;
         wcnt_q      <= '0;
         block_req_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_vld_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vaddr_q     <= vaddr_d;
         left_q      <= left_d;
         wcnt_q      <= wcnt_d;
         block_req_q <= block_req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_vld_q   <= out_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= data18bit;
      end
   end

   assign block_req          = block_req_q;
   assign block_Vaddr        = vaddr_q;
   assign block_pause_ahead1 = pause_sum >= CntW'(DEPTH - 1);
   assign out_vld            = out_vld_q;
   assign out_data           = out_vld_q ? mem[rd_ptr_q] : '0;
   assign busy               = busy_q;
   assign done               = done_q;

`ifdef DDR_RD_CLIENT_CHECK_EN
   logic granted_once_q;
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         granted_once_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         if (state_q == StIdle) begin
            granted_once_q <= 1'b0;
         end else if ((state_q == StReq) && block_granted) begin
            granted_once_q <= 1'b1;
         end
         if (data18bit_vld &&
             (((count_q == CntW'(DEPTH)) && !pop) || (state_q == StIdle) ||
              ((state_q == StReq) && !granted_once_q))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rd_client.sv
// Bench for ddr_rd_client: a scheduler model grants and streams words, a FIFO occupancy model
// predicts pause/out_vld, and popped words are compared against the pushed stream.
module tb_ddr_rd_client;

   localparam int WPB   = 56;
   localparam int STEP  = 64;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset, start, block_req, block_granted, block_pause_ahead1;
   logic [19:0] start_Vaddr, block_Vaddr;
   logic [11:0] nburst;
   logic [17:0] data18bit, out_data;
   logic        data18bit_vld, out_vld, out_rdy, busy, done, err;

   ddr_rd_client dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .start_Vaddr        (start_Vaddr),
      .nburst             (nburst),
      .block_req          (block_req),
      .block_Vaddr        (block_Vaddr),
      .block_granted      (block_granted),
      .block_pause_ahead1 (block_pause_ahead1),
      .data18bit          (data18bit),
      .data18bit_vld      (data18bit_vld),
      .out_data           (out_data),
      .out_vld            (out_vld),
      .out_rdy            (out_rdy),
      .busy               (busy),
      .done               (done),
      .err                (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // test controls
   bit          rst_req, start_req, stray_vld, ignore_pause, seq_data;
   logic [19:0] start_addr;
   logic [11:0] start_n;
   int          rdy_mode, gap_pct, gnt_dly;

   // scheduler and FIFO reference state
   int          cyc, sch_st, gnt_cnt, words_left, word_idx;
   bit          pause_seen;
   int          mcount, max_count, pause_bad, vld_bad, done_cnt, done_cyc, last_vld_cyc;
   logic [17:0] exp_q[$];
   logic [17:0] got_q[$];
   logic [19:0] req_log[$];

   task automatic tick();
      bit exp_pause, mvld, mpop, mpush;
      @(posedge clk);
      #1;
      cyc++;
      reset         = rst_req;
      start         = start_req;
      start_Vaddr   = start_addr;
      nburst        = start_n;
      rst_req       = 1'b0;
      start_req     = 1'b0;
      block_granted = 1'b0;
      data18bit_vld = 1'b0;
      if (reset) begin
         sch_st = 0;
      end else if (sch_st == 1) begin
         if (gnt_cnt == 0) begin
            block_granted = 1'b1;
            req_log.push_back(block_Vaddr);
            words_left = WPB;
            sch_st     = 2;
         end else begin
            gnt_cnt--;
         end
      end else if (sch_st == 2 && (ignore_pause || !pause_seen) &&
                   $urandom_range(99) >= 32'(gap_pct)) begin
         data18bit_vld = 1'b1;
         data18bit     = seq_data ? 18'(word_idx) : 18'($urandom);
         word_idx++;
         words_left--;
         last_vld_cyc = cyc;
         if (words_left == 0) sch_st = 0;
      end
      if (stray_vld) begin
         data18bit_vld = 1'b1;
         data18bit     = 18'($urandom);
         stray_vld     = 1'b0;
      end
      case (rdy_mode)
         0:       out_rdy = 1'b0;
         1:       out_rdy = 1'b1;
         default: out_rdy = 1'($urandom_range(1));
      endcase
      @(negedge clk);
      exp_pause = (mcount + int'(data18bit_vld)) >= DEPTH - 1;
      mvld      = (mcount != 0);
      if (block_pause_ahead1 !== exp_pause) pause_bad++;
      if (out_vld !== mvld) vld_bad++;
      pause_seen = block_pause_ahead1;
      mpop  = mvld && out_rdy;
      mpush = data18bit_vld && (mcount < DEPTH || mpop);
      if (mpop) got_q.push_back(out_data);
      if (mpush) exp_q.push_back(data18bit);
      mcount = mcount + int'(mpush) - int'(mpop);
      if (mcount > max_count) max_count = mcount;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (sch_st == 0 && block_req === 1'b1 && !reset) begin
         sch_st  = 1;
         gnt_cnt = gnt_dly - 1;
      end
      if (reset) begin
         sch_st = 0;
         mcount = 0;
         pause_seen = 1'b0;
         exp_q.delete();
         got_q.delete();
      end
   endtask

   task automatic begin_test();
      ignore_pause = 1'b0;
      rst_req = 1'b1;
      tick();
      tick();
      max_count = 0; pause_bad = 0; vld_bad = 0; done_cnt = 0; word_idx = 0;
      req_log.delete();
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic run_until_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain(input int budget);
      rdy_mode = 1;
      for (int i = 0; i < budget && mcount != 0; i++) tick();
   endtask

   task automatic test_reset();
      rst_req = 1'b1;
      tick();
      rst_req = 1'b1;
      tick();
      checks++;
      if ({block_req, block_Vaddr, block_pause_ahead1, out_vld, out_data, busy, done, err} !== '0)
      begin
         errors++;
         $display("FAIL reset_outputs: req=%b vaddr=%h pause=%b vld=%b data=%h busy=%b done=%b err=%b want all 0",
                  block_req, block_Vaddr, block_pause_ahead1, out_vld, out_data, busy, done, err);
      end
   endtask

   task automatic test_single_burst();
      bit ok;
      begin_test();
      seq_data = 1'b1; rdy_mode = 1; gap_pct = 0; gnt_dly = 2;
      start_addr = 20'h00100; start_n = 12'd1; start_req = 1'b1;
      tick();
      tick();
      checks++;
      if ({block_req, busy} !== 2'b11) begin
         errors++;
         $display("FAIL single_start_latency: req,busy=%b want 11", {block_req, busy});
      end
      run_until_done(300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_done_timeout: got none want done"); end
      checks++;
      if (done_cyc != last_vld_cyc + 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done_timing: done@%0d busy=%b want done@%0d busy=0",
                  done_cyc, busy, last_vld_cyc + 1);
      end
      drain(100);
      checks++;
      if (req_log.size() != 1 || req_log[0] !== 20'h00100) begin
         errors++;
         $display("FAIL single_req: %0d reqs first=%h want 1 req 00100", req_log.size(),
                  req_log.size() > 0 ? req_log[0] : 20'h0);
      end
      checks++;
      if (got_q.size() != WPB) begin
         errors++;
         $display("FAIL single_count: got %0d words want %0d", got_q.size(), WPB);
      end
      for (int i = 0; i < got_q.size() && i < WPB; i++) begin
         checks++;
         if (got_q[i] !== 18'(i)) begin
            errors++;
            $display("FAIL single_data[%0d]: got %h want %h", i, got_q[i], 18'(i));
         end
      end
      checks++;
      if (pause_bad != 0 || vld_bad != 0 || err !== 1'b0 || done_cnt != 1) begin
         errors++;
         $display("FAIL single_misc: pause_bad=%0d vld_bad=%0d err=%b dones=%0d want 0 0 0 1",
                  pause_bad, vld_bad, err, done_cnt);
      end
   endtask

   task automatic test_multi_wrap();
      bit ok;
      begin_test();
      seq_data = 1'b0; rdy_mode = 2; gap_pct = 30; gnt_dly = 3;
      start_addr = 20'hFFFC0; start_n = 12'd3; start_req = 1'b1;
      run_until_done(3000, ok);
      checks++;
      if (!ok || busy !== 1'b0) begin
         errors++;
         $display("FAIL multi_done: ok=%b busy=%b want ok=1 busy=0", ok, busy);
      end
      drain(200);
      checks++;
      if (req_log.size() != 3) begin
         errors++;
         $display("FAIL multi_req_count: got %0d want 3", req_log.size());
      end
      for (int i = 0; i < req_log.size() && i < 3; i++) begin
         checks++;
         if (req_log[i] !== 20'(32'hFFFC0 + 32'(i * STEP))) begin
            errors++;
            $display("FAIL multi_vaddr[%0d]: got %h want %h", i, req_log[i],
                     20'(32'hFFFC0 + 32'(i * STEP)));
         end
      end
      checks++;
      if (got_q.size() != 3 * WPB || exp_q.size() != 3 * WPB) begin
         errors++;
         $display("FAIL multi_count: got %0d sent %0d want %0d", got_q.size(), exp_q.size(), 3 * WPB);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL multi_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (pause_bad != 0 || vld_bad != 0 || err !== 1'b0) begin
         errors++;
         $display("FAIL multi_misc: pause_bad=%0d vld_bad=%0d err=%b want 0 0 0",
                  pause_bad, vld_bad, err);
      end
   endtask

   task automatic test_backpressure_full();
      bit ok;
      begin_test();
      seq_data = 1'b0; rdy_mode = 0; gap_pct = 0; gnt_dly = 2;
      start_addr = 20'h00400; start_n = 12'd2; start_req = 1'b1;
      for (int i = 0; i < 400 && mcount < DEPTH - 1; i++) tick();
      repeat (5) tick();
      checks++;
      if (mcount != DEPTH - 1 || block_pause_ahead1 !== 1'b1) begin
         errors++;
         $display("FAIL bp_fill: count=%0d pause=%b want %0d 1", mcount, block_pause_ahead1, DEPTH - 1);
      end
      // one word past the pause fills the last slot, then push+pop at full
      ignore_pause = 1'b1;
      tick();
      rdy_mode = 1;
      repeat (5) tick();
      ignore_pause = 1'b0;
      checks++;
      if (mcount != DEPTH || max_count != DEPTH || out_vld !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: count=%0d peak=%0d vld=%b want %0d %0d 1",
                  mcount, max_count, out_vld, DEPTH, DEPTH);
      end
      rdy_mode = 2; gap_pct = 20;
      run_until_done(3000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_done_timeout: got none want done"); end
      drain(200);
      checks++;
      if (got_q.size() != 2 * WPB || exp_q.size() != 2 * WPB) begin
         errors++;
         $display("FAIL bp_count: got %0d sent %0d want %0d", got_q.size(), exp_q.size(), 2 * WPB);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (req_log.size() != 2 || req_log[0] !== 20'h00400 || req_log[1] !== 20'h00440) begin
         errors++;
         $display("FAIL bp_req: %0d reqs want 00400,00440", req_log.size());
      end
      checks++;
      if (pause_bad != 0 || vld_bad != 0 || err !== 1'b0) begin
         errors++;
         $display("FAIL bp_misc: pause_bad=%0d vld_bad=%0d err=%b want 0 0 0",
                  pause_bad, vld_bad, err);
      end
   endtask

   task automatic test_start_busy_and_zero();
      bit ok;
      begin_test();
      seq_data = 1'b0; rdy_mode = 1; gap_pct = 0; gnt_dly = 2;
      start_addr = 20'h00005; start_n = 12'd0; start_req = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, block_req} !== 3'b100) begin
         errors++;
         $display("FAIL zero_t1: busy,done,req=%b want 100", {busy, done, block_req});
      end
      tick();
      checks++;
      if ({busy, done, block_req} !== 3'b010) begin
         errors++;
         $display("FAIL zero_t2: busy,done,req=%b want 010", {busy, done, block_req});
      end
      tick();
      start_addr = 20'h02000; start_n = 12'd1; start_req = 1'b1;
      repeat (10) tick();
      start_addr = 20'h03000; start_n = 12'd5; start_req = 1'b1;
      run_until_done(400, ok);
      repeat (10) tick();
      checks++;
      if (!ok || done_cnt != 2 || block_req !== 1'b0 || req_log.size() != 1 ||
          req_log[0] !== 20'h02000) begin
         errors++;
         $display("FAIL busy_start: ok=%b dones=%0d req=%b nreq=%0d want 1 2 0 1 (02000)",
                  ok, done_cnt, block_req, req_log.size());
      end
      drain(100);
      checks++;
      if (got_q.size() != WPB || got_q != exp_q) begin
         errors++;
         $display("FAIL busy_data: got %0d words want %0d in order", got_q.size(), WPB);
      end
   endtask

   task automatic test_reset_mid_stream();
      begin_test();
      seq_data = 1'b1; rdy_mode = 1; gap_pct = 0; gnt_dly = 2;
      start_addr = 20'h00800; start_n = 12'd1; start_req = 1'b1;
      for (int i = 0; i < 200 && word_idx < 20; i++) tick();
      checks++;
      if (busy !== 1'b1 || word_idx != 20) begin
         errors++;
         $display("FAIL mid_stream: busy=%b words=%0d want 1 20", busy, word_idx);
      end
      rst_req = 1'b1;
      tick();
      tick();
      checks++;
      if ({block_req, block_Vaddr, block_pause_ahead1, out_vld, out_data, busy, done, err} !== '0)
      begin
         errors++;
         $display("FAIL mid_reset: req=%b vaddr=%h pause=%b vld=%b data=%h busy=%b done=%b err=%b want all 0",
                  block_req, block_Vaddr, block_pause_ahead1, out_vld, out_data, busy, done, err);
      end
      stray_vld = 1'b1;
      tick();
      tick();
`ifdef DDR_RD_CLIENT_CHECK_EN
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL stray_err: got %b want 1", err); end
`else
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL stray_err: got %b want 0", err); end
`endif
      rst_req = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start_Vaddr = '0; nburst = '0;
      block_granted = 1'b0; data18bit = '0; data18bit_vld = 1'b0; out_rdy = 1'b0;
      rst_req = 1'b0; start_req = 1'b0; stray_vld = 1'b0; ignore_pause = 1'b0; seq_data = 1'b0;
      start_addr = '0; start_n = '0; rdy_mode = 0; gap_pct = 0; gnt_dly = 2;
      cyc = 0; sch_st = 0; gnt_cnt = 0; words_left = 0; word_idx = 0; pause_seen = 1'b0;
      mcount = 0; max_count = 0; pause_bad = 0; vld_bad = 0; done_cnt = 0;
      done_cyc = -1; last_vld_cyc = -1;
      test_reset();
      test_single_burst();
      test_multi_wrap();
      test_backpressure_full();
      test_start_busy_and_zero();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ddr_rd_client.md
# ddr_rd_client

Block-side fetch client for the DDR read scheduler. It issues a sequence of burst requests (Vaddr/req) for one scheduler port and accepts the 18-bit word stream the scheduler returns. It throttles that stream with the one-cycle-ahead pause, buffers the words in a first-word-fall-through FIFO, and presents them to the compute stage over a valid/ready interface. One instance sits on each scheduler port.

## Interface
Parameters:
- WIDTH_Vaddr, 20, width of Vaddr; must be ≤ the scheduler's MAX_WIDTH_Vaddr, zero-extended at the flat bus.
- WIDTH_nburst, 12, width of the burst-count input.
- WORDS_PER_BURST, 56, 18-bit words the scheduler delivers per grant.
- VADDR_STEP, 64, Vaddr increment per burst (16-bit DDR words).
- DEPTH, 64, FIFO depth in 18-bit words; power of two, ≥ 4.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- start_Vaddr  in  WIDTH_Vaddr  first-burst Vaddr, sampled with start.
- nburst  in  WIDTH_nburst  number of bursts, sampled with start; 0 is treated as a 1-cycle no-op.
- block_req  out  1  burst request to the scheduler.
- block_Vaddr  out  WIDTH_Vaddr  burst Vaddr; stable while block_req=1.
- block_granted  in  1  one-cycle grant from the scheduler.
- block_pause_ahead1  out  1  pause to the scheduler for the next word.
- data18bit  in  18  word from the scheduler.
- data18bit_vld  in  1  word valid.
- out_data  out  18  FIFO head word.
- out_vld  out  1  FIFO non-empty.
- out_rdy  in  1  consumer accepts out_data when out_vld=1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last word of the last burst is written into the FIFO.
- err  out  1  sticky error flag; see Configuration.

## Operation
- States are IDLE, REQ, STREAM and DONE.
- **IDLE**
  - On start with nburst≠0: latch Vaddr←start_Vaddr and left←nburst, then go to REQ.
  - On start with nburst=0: go to DONE.
- **REQ**
  - block_req=1 and block_Vaddr=Vaddr.
  - On block_granted: go to STREAM and set wcnt←0. block_req is low from the next cycle.
- **STREAM**
  - Each data18bit_vld increments wcnt.
  - When wcnt reaches WORDS_PER_BURST-1 with vld present, left decrements.
  - If left>1: Vaddr←Vaddr+VADDR_STEP (mod 2^WIDTH_Vaddr) and go to REQ.
  - Otherwise go to DONE.
- **DONE**: done=1 for one cycle, then go to IDLE.
- **FIFO push**: data18bit_vld writes data18bit. Words are accepted in any state; only the STREAM counter tracks them.
- **FIFO pop**: out_vld & out_rdy.
- **Pause**: block_pause_ahead1 = (count + data18bit_vld) ≥ DEPTH-1, combinational. A word launched by the scheduler after seeing pause=0 therefore always fits, so push never occurs while full.
- **Push and pop in the same cycle**: count is unchanged, including at full and at empty. At empty, the pushed word is visible on out_data the next cycle.
- **start while busy**: ignored.
- **Reset**: resets the block regardless of state. It is mid-operation safe only if the scheduler is reset in the same cycle.

## Timing
- Reset values:
  - block_req=0, block_Vaddr=0, block_pause_ahead1=0.
  - out_vld=0, out_data=0 (FIFO empty).
  - busy=0, done=0, err=0.
  - State IDLE; FIFO pointers and count cleared.
- start at cycle t: block_req=1 and busy=1 at t+1.
- block_granted at cycle g: block_req=0 at g+1.
- Next request: block_req rises the cycle after the last vld of the current burst.
- Write-to-read latency: a word with vld at cycle v appears on out_data/out_vld at v+1 at the earliest.
- done rises the cycle after the final vld. busy falls together with done.
- All outputs are registered except block_pause_ahead1 and out_data. out_data reads the memory at rd_ptr.

## Configuration
- DDR_RD_CLIENT_CHECK_EN defined: err sets and holds until reset when either of the following occurs:
  - a push happens while count=DEPTH without a same-cycle pop;
  - data18bit_vld arrives while in IDLE, or while in REQ before the first grant.
- DDR_RD_CLIENT_CHECK_EN undefined: err tied to 0 and the check logic is absent. FIFO and FSM behaviour are identical in both builds.

## Test plan
- **Single burst:** start, start_Vaddr=0x100, nburst=1, out_rdy=1, model grants after 2 cycles and streams 56 words 0..55 → block_Vaddr=0x100, one req/grant pair, out_data emits 0..55 in order, done one cycle after the last vld, err=0.
- **Multi-burst Vaddr and wrap:** nburst=3, start_Vaddr=0xFFFC0 → requests carry 0xFFFC0, 0x00000, 0x00040, in that order; 168 words out.
- **Backpressure:** DEPTH=64, out_rdy=0 → block_pause_ahead1 rises when count+vld=63; count peaks at exactly 64; no overflow, err=0. Releasing out_rdy drains all 56 words of burst 1 and lets burst 2 complete.
- **Simultaneous push/pop at full and at empty:** count stays constant; data order preserved.
- **start while busy, and nburst=0:** start while busy is ignored. nburst=0 → done at t+2 with no block_req.
- **Reset mid-STREAM after 20 words:** all outputs return to their reset values the next cycle. With CHECK_EN, a stray vld in IDLE sets err=1.
